avalon_st_pkt_sampler: RTL and testbench

- Parametrised Avalon-ST buffering stage for the message path. Sits between an Avalon-ST source and sink.
- Stores up to CAPACITY beats, carrying data plus startofpacket/endofpacket.
- Optional store-and-forward mode holds output until a complete packet is buffered.
- Exposes fill and packet-count status.

---
 rtl/avalon_st_pkt_sampler.sv | 114 +++++++++++
 tb/tb_avalon_st_pkt_sampler.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/avalon_st_pkt_sampler.sv
// Avalon-ST buffering stage: circular buffer with show-ahead head, optional
// store-and-forward release, and fill/packet-count status.
module avalon_st_pkt_sampler #(
  parameter int DATA_WIDTH        = 32,
  parameter int CAPACITY          = 2,
  parameter bit STORE_AND_FORWARD = 1'b0,
  parameter bit SUPPRESS_WARNING  = 1'b0
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [DATA_WIDTH-1:0]          in_data,
  input  logic                           in_sop,
  input  logic                           in_eop,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [DATA_WIDTH-1:0]          out_data,
  output logic                           out_sop,
  output logic                           out_eop,
  output logic [$clog2(CAPACITY+1)-1:0]  fill_level,
  output logic [$clog2(CAPACITY+1)-1:0]  pkt_count
);

  localparam int DEPTH = (CAPACITY > 0) ? CAPACITY : 1;
  localparam int CW    = $clog2(CAPACITY + 1);
  localparam int PW    = (CAPACITY > 1) ? $clog2(CAPACITY) : 1;

  generate
    if (CAPACITY == 0) begin : g_cap_zero
      $error("avalon_st_pkt_sampler: CAPACITY must be at least 1");
      $fatal(1, "avalon_st_pkt_sampler: illegal CAPACITY=0");
    end
    if (CAPACITY == 1 && !SUPPRESS_WARNING) begin : g_cap_one
      $warning("avalon_st_pkt_sampler: CAPACITY=1 limits throughput to half rate");
    end
    if (CAPACITY > 16 && !SUPPRESS_WARNING) begin : g_cap_big
      $warning("avalon_st_pkt_sampler: CAPACITY>16, consider a dedicated FIFO");
    end
  endgenerate

  typedef struct packed {
    logic                  sop;
    logic                  eop;
    logic [DATA_WIDTH-1:0] data;
  } beat_t;

  beat_t         mem [DEPTH];
  beat_t         head;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] fill_nxt, pkt_nxt;
  logic          fwd;
  logic          push, pop;
  logic          pkt_inc, pkt_dec;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    // Explicit wrap so non-power-of-two depths work.
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign head      = mem[rd_ptr];
  assign out_data  = head.data;
  assign out_sop   = head.sop;
  assign out_eop   = head.eop;

  // in_ready depends on registered fill only; no out_ready -> in_ready path.
  assign in_ready  = (fill_level < CW'(CAPACITY));
  assign out_valid = (fill_level != '0) &&
                     (!STORE_AND_FORWARD || (pkt_count != '0) || fwd);

  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign pkt_inc   = push & in_eop;
  assign pkt_dec   = pop & head.eop;

  always_comb begin
    fill_nxt = fill_level;
    if (push && !pop)      fill_nxt = fill_level + CW'(1);
    else if (pop && !push) fill_nxt = fill_level - CW'(1);
  end

  always_comb begin
    pkt_nxt = pkt_count;
    if (pkt_inc && !pkt_dec)      pkt_nxt = pkt_count + CW'(1);
    else if (pkt_dec && !pkt_inc) pkt_nxt = pkt_count - CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fill_level <= '0;
      pkt_count  <= '0;
      fwd        <= 1'b0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      fill_level <= fill_nxt;
      pkt_count  <= pkt_nxt;
      // Oversized-packet fallback: a full buffer with no EOP would deadlock.
      if (!STORE_AND_FORWARD)
        fwd <= 1'b0;
      else if (pkt_dec)
        fwd <= 1'b0;
      else if (fill_nxt == CW'(CAPACITY) && pkt_nxt == '0)
        fwd <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{sop: in_sop, eop: in_eop, data: in_data};
  end

endmodule

// File: tb/tb_avalon_st_pkt_sampler.sv
// Randomized bench: five configurations in parallel, each checked against a
// queue-based reference model of the buffering rules.
module tb_avalon_st_pkt_sampler;

  localparam int NI = 5;
  localparam int CAPS [NI] = '{2, 4, 1, 8, 4};
  localparam bit SAFS [NI] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

  logic        clk, rst_n;
  logic        iv [NI], ir [NI], isop [NI], ieop [NI];
  logic        ov [NI], ordy [NI], osop [NI], oeop [NI];
  logic [31:0] idat [NI], odat [NI];
  logic [7:0]  fl [NI], pc [NI];

  genvar g;
  generate
    for (g = 0; g < NI; g++) begin : g_dut
      localparam int CW = $clog2(CAPS[g] + 1);
      logic [CW-1:0] fl_w, pc_w;
      avalon_st_pkt_sampler #(
        .DATA_WIDTH(32), .CAPACITY(CAPS[g]),
        .STORE_AND_FORWARD(SAFS[g]), .SUPPRESS_WARNING(1'b1)
      ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv[g]), .in_ready(ir[g]), .in_data(idat[g]),
        .in_sop(isop[g]), .in_eop(ieop[g]),
        .out_valid(ov[g]), .out_ready(ordy[g]), .out_data(odat[g]),
        .out_sop(osop[g]), .out_eop(oeop[g]),
        .fill_level(fl_w), .pkt_count(pc_w)
      );
      assign fl[g] = 8'(fl_w);
      assign pc[g] = 8'(pc_w);
    end
  endgenerate

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d;
    logic        s;
    logic        e;
  } mb_t;

  mb_t mq [NI][$];
  bit  mfwd [NI];
  bit  taken [NI];
  bit  nsop [NI];
  int  n_chk, n_fail;
  bit  hr_on;
  int  hr_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic string tg(input int i, input string s);
    return $sformatf("u%0d_%s", i, s);
  endfunction

  function automatic int m_pkt(input int i);
    int n = 0;
    foreach (mq[i][k]) if (mq[i][k].e) n++;
    return n;
  endfunction

  function automatic bit m_valid(input int i);
    return (mq[i].size() > 0) && (!SAFS[i] || m_pkt(i) > 0 || mfwd[i]);
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NI; i++) begin
      mq[i].delete();
      mfwd[i]  = 1'b0;
      taken[i] = 1'b0;
      nsop[i]  = 1'b1;
      iv[i]    = 1'b0;
      ordy[i]  = 1'b0;
    end
  endtask

  task automatic check_state();
    for (int i = 0; i < NI; i++) begin
      chk(tg(i, "in_ready"), 32'(ir[i]), 32'(mq[i].size() < CAPS[i]));
      chk(tg(i, "fill"), 32'(fl[i]), 32'(mq[i].size()));
      chk(tg(i, "pkt"), 32'(pc[i]), 32'(m_pkt(i)));
      chk(tg(i, "out_valid"), 32'(ov[i]), 32'(m_valid(i)));
      if (m_valid(i)) begin
        chk(tg(i, "data"), odat[i], mq[i][0].d);
        chk(tg(i, "sop"), 32'(osop[i]), 32'(mq[i][0].s));
        chk(tg(i, "eop"), 32'(oeop[i]), 32'(mq[i][0].e));
      end
    end
  endtask

  task automatic step(input int p_in, input int p_out, input int eop_pct);
    bit  push [NI];
    bit  pop  [NI];
    int  old;
    mb_t b;
    @(negedge clk);
    check_state();
    for (int i = 0; i < NI; i++) begin
      // A beat offered but not accepted is held unchanged by the source.
      if (!iv[i] || taken[i]) begin
        taken[i] = 1'b0;
        iv[i]    = ($urandom_range(99) < p_in);
        if (iv[i]) begin
          idat[i] = $urandom;
          isop[i] = nsop[i];
          ieop[i] = ($urandom_range(99) < eop_pct);
          nsop[i] = ieop[i];
        end
      end
      ordy[i] = ($urandom_range(99) < p_out);
      push[i] = iv[i] && (mq[i].size() < CAPS[i]);
      pop[i]  = m_valid(i) && ordy[i];
    end
    if (hr_on && iv[2] && ir[2]) hr_cnt++;
    @(posedge clk);
    for (int i = 0; i < NI; i++) begin
      old = mq[i].size();
      b   = '{d: 32'h0, s: 1'b0, e: 1'b0};
      if (pop[i]) b = mq[i].pop_front();
      if (push[i]) begin
        mq[i].push_back('{d: idat[i], s: isop[i], e: ieop[i]});
        taken[i] = 1'b1;
      end
      if (SAFS[i]) begin
        if (pop[i] && b.e)
          mfwd[i] = 1'b0;
        else if (mq[i].size() == CAPS[i] && old != CAPS[i] && m_pkt(i) == 0)
          mfwd[i] = 1'b1;
      end
    end
  endtask

  task automatic run(input int n, input int p_in, input int p_out, input int eop_pct);
    for (int c = 0; c < n; c++) step(p_in, p_out, eop_pct);
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    hr_on  = 1'b0;
    hr_cnt = 0;
    for (int i = 0; i < NI; i++) begin
      idat[i] = '0; isop[i] = 1'b0; ieop[i] = 1'b0;
    end
    model_clear();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_state();
    rst_n = 1'b1;

    run(20, 100, 100, 25);          // back-to-back streaming
    run(12, 100, 0, 25);            // full backpressure
    run(6, 0, 100, 25);             // drain
    hr_on = 1'b1;
    run(10, 100, 100, 25);          // CAPACITY=1 alternates
    hr_on = 1'b0;
    chk("half_rate_beats", 32'(hr_cnt), 32'd5);

    run(500, 70, 70, 25);
    run(400, 90, 40, 10);           // long packets exercise the fallback
    run(400, 40, 90, 30);
    run(300, 95, 95, 5);

    // Asynchronous reset mid-operation with beats held.
    run(10, 100, 0, 20);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < NI; i++) begin
      chk(tg(i, "rst_fill"), 32'(fl[i]), 32'd0);
      chk(tg(i, "rst_pkt"), 32'(pc[i]), 32'd0);
      chk(tg(i, "rst_valid"), 32'(ov[i]), 32'd0);
    end
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    run(300, 70, 70, 25);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
